// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle ARM controller: FSM states, datapath
// select codes, ALU commands and condition codes, plus condition evaluation.
// Pure declarations; no state, no timing.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    // ALUControl
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // ALUSrcB
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ResultSrc
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // Instruction classes (Op field)
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Data-processing commands (Funct[4:1])
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Condition codes
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // nzcv = {N, Z, C, V}; the reserved 1111 code never executes.
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cond)
            COND_EQ: cond_eval = z;
            COND_NE: cond_eval = ~z;
            COND_CS: cond_eval = c;
            COND_CC: cond_eval = ~c;
            COND_MI: cond_eval = n;
            COND_PL: cond_eval = ~n;
            COND_VS: cond_eval = v;
            COND_VC: cond_eval = ~v;
            COND_HI: cond_eval = c & ~z;
            COND_LS: cond_eval = ~c | z;
            COND_GE: cond_eval = (n == v);
            COND_LT: cond_eval = (n != v);
            COND_GT: cond_eval = ~z & (n == v);
            COND_LE: cond_eval = z | (n != v);
            COND_AL: cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_mainfsm.sv
// Main sequencing FSM: state register, next state and Moore datapath controls.
// Latency: one state per cycle; 3-5 cycles per instruction. No backpressure.
// Ports: clk/reset; Op, is_imm (Funct[5]), is_load (Funct[0]), NoWrite in;
//        state plus raw (ungated) NextPC/Branch/RegW/MemW and select outputs.
module mc_mainfsm
    import multicycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic       is_imm,
    input  logic       is_load,
    input  logic       NoWrite,
    output state_t     state,
    output logic       NextPC,
    output logic       Branch,
    output logic       RegW,
    output logic       MemW,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ALUOp
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    case (Op)
                        OP_MEM:  state <= S_MEMADR;
                        OP_DP:   state <= is_imm ? S_EXECUTEI : S_EXECUTER;
                        OP_BR:   state <= S_BRANCH;
                        default: state <= S_FETCH;   // undefined class retires as a NOP
                    endcase
                end
                S_MEMADR:   state <= is_load ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  state <= S_MEMWB;
                S_EXECUTER: state <= S_ALUWB;
                S_EXECUTEI: state <= S_ALUWB;
                default:    state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        NextPC    = 1'b0;
        Branch    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_REG;
        ALUOp     = 1'b0;
        case (state)
            S_FETCH: begin
                IRWrite   = 1'b1;
                NextPC    = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_DECODE: begin
                // PC+4 again gives PC+8 for an R15 operand read
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_MEMADR:   ALUSrcB = SRCB_IMM;
            S_MEMREAD:  AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegW      = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            S_EXECUTER: ALUOp = 1'b1;
            S_EXECUTEI: begin
                ALUSrcB = SRCB_IMM;
                ALUOp   = 1'b1;
            end
            S_ALUWB:    RegW = ~NoWrite;
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                Branch    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: instruction decode, NZCV flags, condition gating.
// Latency: B=3, DP/STR=4, LDR=5 cycles; failed conditions take full length.
// Ports: clk, reset, Instr[31:12], ALUFlags in; all datapath enables/selects out.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:12] Instr,
    input  logic [3:0]   ALUFlags,
    output logic         PCWrite,
    output logic         AdrSrc,
    output logic         MemWrite,
    output logic         IRWrite,
    output logic [1:0]   ResultSrc,
    output logic         ALUSrcA,
    output logic [1:0]   ALUSrcB,
    output logic [1:0]   ALUControl,
    output logic [1:0]   ImmSrc,
    output logic [1:0]   RegSrc,
    output logic         RegWrite,
    output logic         Byte
);

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       unused_rn;

    assign cond      = Instr[31:28];
    assign op        = Instr[27:26];
    assign funct     = Instr[25:20];
    assign rd        = Instr[15:12];
    assign unused_rn = ^Instr[19:16];

    state_t     state;
    logic       next_pc, branch, reg_w, mem_w, ir_write, alu_op;
    logic       no_write;
    logic [1:0] alu_ctl, flag_w;
    logic [3:0] flags;
    logic       cond_ex, cond_ex_d;

    mc_mainfsm u_fsm (
        .clk       (clk),
        .reset     (reset),
        .Op        (op),
        .is_imm    (funct[5]),
        .is_load   (funct[0]),
        .NoWrite   (no_write),
        .state     (state),
        .NextPC    (next_pc),
        .Branch    (branch),
        .RegW      (reg_w),
        .MemW      (mem_w),
        .IRWrite   (ir_write),
        .AdrSrc    (AdrSrc),
        .ResultSrc (ResultSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (alu_op)
    );

    // NoWrite is decoded unconditionally because ALUWB (ALUOp=0) still needs it.
    always_comb begin
        alu_ctl  = ALU_ADD;
        flag_w   = 2'b00;
        no_write = 1'b1;
        case (funct[4:1])
            CMD_ADD: begin alu_ctl = ALU_ADD; no_write = 1'b0; flag_w = funct[0] ? 2'b11 : 2'b00; end
            CMD_SUB: begin alu_ctl = ALU_SUB; no_write = 1'b0; flag_w = funct[0] ? 2'b11 : 2'b00; end
            CMD_AND: begin alu_ctl = ALU_AND; no_write = 1'b0; flag_w = funct[0] ? 2'b10 : 2'b00; end
            CMD_ORR: begin alu_ctl = ALU_ORR; no_write = 1'b0; flag_w = funct[0] ? 2'b10 : 2'b00; end
            CMD_CMP: begin alu_ctl = ALU_SUB; flag_w = 2'b11; end
            default: ;
        endcase
    end

    logic [1:0] flag_w_act;
    assign ALUControl = alu_op ? alu_ctl : ALU_ADD;
    assign flag_w_act = alu_op ? flag_w : 2'b00;

    assign cond_ex = cond_eval(cond, flags);

    // cond_ex_d carries the execute-cycle verdict into the write cycle, so the
    // write sees the flags as they were before this instruction updated them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags     <= RESET_FLAGS;
            cond_ex_d <= 1'b0;
        end else begin
            cond_ex_d <= cond_ex;
            if (cond_ex && flag_w_act[1]) flags[3:2] <= ALUFlags[3:2];
            if (cond_ex && flag_w_act[0]) flags[1:0] <= ALUFlags[1:0];
        end
    end

    assign RegWrite = ~reset & reg_w & cond_ex_d;
    assign MemWrite = ~reset & mem_w & cond_ex_d;
    assign IRWrite  = ~reset & ir_write;
    assign PCWrite  = ~reset & (next_pc | (branch & cond_ex_d) |
                                (reg_w & cond_ex_d & (rd == 4'd15)));

    assign ImmSrc = op;
    assign RegSrc = {op == OP_MEM, op == OP_BR};
    assign Byte   = funct[2] & (op == OP_MEM) &
                    ((state == S_MEMREAD) || (state == S_MEMWB) || (state == S_MEMWRITE));

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a driver pushes the hand-derived
// per-cycle control vector, a negedge monitor pops and compares it.
module tb_multicycle_controller;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:12] Instr;
    logic [3:0]   ALUFlags;
    logic         PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite, Byte;
    logic [1:0]   ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .RegWrite   (RegWrite),
        .Byte       (Byte)
    );

    typedef struct packed {
        logic       pcw, adr, memw, irw;
        logic [1:0] rs;
        logic       sa;
        logic [1:0] sb;
        logic [1:0] alu;
        logic       regw, byt;
    } ctl_t;

    typedef struct {
        string      nm;
        ctl_t       c;
        logic [1:0] imm;
        logic [1:0] rsrc;
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad   = 0;
    logic [1:0] cur_imm, cur_rsrc;
    ctl_t       F, D, R, MA;

    function automatic ctl_t mk(input logic pcw, input logic adr, input logic memw,
                                input logic irw, input logic [1:0] rs, input logic sa,
                                input logic [1:0] sb, input logic [1:0] alu,
                                input logic regw, input logic byt);
        ctl_t c;
        c.pcw = pcw; c.adr = adr; c.memw = memw; c.irw = irw; c.rs = rs;
        c.sa = sa; c.sb = sb; c.alu = alu; c.regw = regw; c.byt = byt;
        return c;
    endfunction

    // Monitor: one expected vector per cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        ctl_t g;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            g = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                 ALUControl, RegWrite, Byte};
            total++;
            if (g !== e.c || ImmSrc !== e.imm || RegSrc !== e.rsrc) begin
                bad++;
                $display("FAIL %s got ctl=%b imm=%b rsrc=%b need ctl=%b imm=%b rsrc=%b",
                         e.nm, g, ImmSrc, RegSrc, e.c, e.imm, e.rsrc);
            end
        end
    end

    task automatic push(input string nm, input ctl_t c);
        exp_t e;
        e.nm = nm; e.c = c; e.imm = cur_imm; e.rsrc = cur_rsrc;
        exp_q.push_back(e);
    endtask

    task automatic step(input string nm, input ctl_t c);
        push(nm, c);
        @(posedge clk); #1;
    endtask

    // IR is loaded at the edge ending FETCH, so the new word appears in DECODE.
    task automatic load_ir(input logic [31:12] ins, input logic [1:0] imm, input logic [1:0] rsrc);
        Instr    = ins;
        cur_imm  = imm;
        cur_rsrc = rsrc;
    endtask

    task automatic dp(input string nm, input logic [31:12] ins, input logic imm_form,
                      input logic [1:0] alu, input logic [3:0] fl,
                      input logic regw, input logic pcw);
        step({nm, ":fetch"}, F);
        load_ir(ins, 2'b00, 2'b00);
        step({nm, ":decode"}, D);
        ALUFlags = fl;
        step({nm, ":exec"}, mk(0, 0, 0, 0, 2'b00, 0, imm_form ? 2'b01 : 2'b00, alu, 0, 0));
        ALUFlags = 4'b0000;
        step({nm, ":aluwb"}, mk(pcw, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, regw, 0));
    endtask

    task automatic mem(input string nm, input logic [31:12] ins, input logic load,
                       input logic byt, input logic w);
        step({nm, ":fetch"}, F);
        load_ir(ins, 2'b01, 2'b10);
        step({nm, ":decode"}, D);
        step({nm, ":memadr"}, MA);
        if (load) begin
            step({nm, ":memread"}, mk(0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, byt));
            step({nm, ":memwb"},   mk(0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, w, byt));
        end else begin
            step({nm, ":memwrite"}, mk(0, 1, w, 0, 2'b00, 0, 2'b00, 2'b00, 0, byt));
        end
    endtask

    task automatic br(input string nm, input logic [31:12] ins, input logic taken);
        step({nm, ":fetch"}, F);
        load_ir(ins, 2'b10, 2'b01);
        step({nm, ":decode"}, D);
        step({nm, ":branch"}, mk(taken, 0, 0, 0, 2'b10, 0, 2'b01, 2'b00, 0, 0));
    endtask

    initial begin
        F  = mk(1, 0, 0, 1, 2'b10, 1, 2'b10, 2'b00, 0, 0);
        D  = mk(0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00, 0, 0);
        R  = mk(0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00, 0, 0);
        MA = mk(0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 0, 0);

        reset    = 1'b1;
        ALUFlags = 4'b0000;
        load_ir(20'h00000, 2'b00, 2'b00);
        @(posedge clk); #1;
        step("reset_hold0", R);
        step("reset_hold1", R);
        reset = 1'b0;

        // flags after each line noted as NZCV
        dp("adds",    20'hE0921, 0, 2'b00, 4'b0100, 1, 0);   // 0100
        dp("addne_z", 20'h10821, 0, 2'b00, 4'b0000, 0, 0);
        dp("addeq_z", 20'h00821, 0, 2'b00, 4'b0000, 1, 0);
        mem("ldrb",   20'hE5D10, 1, 1, 1);
        mem("str",    20'hE5810, 0, 0, 1);
        dp("cmp",     20'hE1510, 0, 2'b01, 4'b0010, 0, 0);   // 0010
        br("beq_nt",  20'h0A000, 0);
        br("bne_t",   20'h1A000, 1);
        dp("add_pc",  20'hE082F, 0, 2'b00, 4'b0000, 1, 1);
        step("undef:fetch", F);
        load_ir(20'hEC000, 2'b11, 2'b00);
        step("undef:decode", D);
        dp("ands",    20'hE0121, 0, 2'b10, 4'b1001, 1, 0);   // 1010: CV kept
        dp("addcs",   20'h20821, 0, 2'b00, 4'b0000, 1, 0);
        dp("addmi",   20'h40821, 0, 2'b00, 4'b0000, 1, 0);
        dp("addvs",   20'h60821, 0, 2'b00, 4'b0000, 0, 0);
        dp("subseq_f",20'h00521, 0, 2'b01, 4'b0100, 0, 0);   // not executed: 1010
        dp("addne",   20'h10821, 0, 2'b00, 4'b0000, 1, 0);
        dp("orr",     20'hE1821, 0, 2'b11, 4'b0000, 1, 0);
        dp("eor_nop", 20'hE0221, 0, 2'b00, 4'b0000, 0, 0);
        dp("addi",    20'hE2811, 1, 2'b00, 4'b0000, 1, 0);

        // Set Z, then reset in the middle of MEMADR: flags must return to 0000.
        dp("adds2",   20'hE0921, 0, 2'b00, 4'b0100, 1, 0);
        step("rst:fetch", F);
        load_ir(20'hE5D10, 2'b01, 2'b10);
        step("rst:decode", D);
        push("rst:memadr", MA);
        @(negedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        step("rst:held", R);
        reset = 1'b0;
        dp("addeq_rst", 20'h00821, 0, 2'b00, 4'b0000, 0, 0);
        dp("addne_rst", 20'h10821, 0, 2'b00, 4'b0000, 1, 0);

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got pending=%0d need 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
